// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and helpers for the PWM peripheral.
//   PWM_CNT_W      : width of the PWM period counter (8-bit duty resolution)
//   NUM_CH         : number of gated output channels
//   PWM_DUTY_FULL  : duty code that forces the level permanently high
//   PWM_CNT_MAX    : last count of a period, where the counter wraps
//   div_cnt_width(): prescaler counter width for a given divide ratio
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_CH    = 16;

    localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX   = 8'hFF;

    // $clog2(1) is 0; a zero-width counter is not legal, so floor it at 1.
    function automatic int div_cnt_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Prescaler plus 8-bit period counter shared by every PWM channel.
// Ports:
//   clk_i      : system clock
//   rst_n_i    : asynchronous active-low reset
//   pwm_cnt_o  : current position within the PWM period (0..255)
//   wrap_o     : high in the cycle whose clock edge takes pwm_cnt 255 -> 0
// Parameter CLK_DIV: system clocks per counter tick (1..65535).
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    output logic [PWM_CNT_W-1:0] pwm_cnt_o,
    output logic                 wrap_o
);

    localparam int               DIV_W    = div_cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 tick;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        // Natural 8-bit overflow provides the 255 -> 0 wrap.
        pwm_cnt_d = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt_o = pwm_cnt_q;
    assign wrap_o    = tick && (pwm_cnt_q == PWM_CNT_MAX);

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Generates one shared PWM waveform and gates it onto 16 chip outputs using
// the output-enable / PWM-enable registers written over SPI.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   en_reg_out_7_0/15_8 : per-channel output enable
//   en_reg_pwm_7_0/15_8 : per-channel PWM select (else constant high)
//   pwm_duty_cycle      : duty code, 0x00 = 0 %, 0xFF = 100 %
//   out[15:0]           : registered channel outputs ([7:0] uo_out, [15:8] uio_out)
//   period_start        : registered one-clock pulse when the period restarts
// Parameter CLK_DIV: system clocks per PWM counter tick; period = 256*CLK_DIV.
// Build option PWM_SHADOW_UPDATE_EN: when defined, the duty is held in a shadow
// register reloaded only at the period wrap so changes never cut a period short.
// -----------------------------------------------------------------------------
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic                 wrap;
    logic [PWM_CNT_W-1:0] duty_act;
    logic                 pwm_level;
    logic [NUM_CH-1:0]    en_out, en_pwm;
    logic [NUM_CH-1:0]    out_q, out_d;
    logic                 period_start_q;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .pwm_cnt_o (pwm_cnt),
        .wrap_o    (wrap)
    );

`ifdef PWM_SHADOW_UPDATE_EN
    logic [PWM_CNT_W-1:0] duty_q, duty_d;

    // Loading on the wrap edge itself means the duty sampled there governs
    // the whole period that begins at pwm_cnt = 0.
    always_comb duty_d = wrap ? pwm_duty_cycle : duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_q <= '0;
        else        duty_q <= duty_d;
    end

    assign duty_act = duty_q;
`else
    assign duty_act = pwm_duty_cycle;
`endif

    always_comb begin
        // 0xFF must not drop low at pwm_cnt = 255, so it bypasses the compare.
        pwm_level = (duty_act == PWM_DUTY_FULL) || (pwm_cnt < duty_act);
        en_out    = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_d     = en_out & (~en_pwm | {NUM_CH{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
// Directed bench for pwm_peripheral with CLK_DIV = 4 (1024-clock period).
// Expected values are queued when a scenario is set up and popped when the
// matching DUT observation is taken. Builds with or without
// PWM_SHADOW_UPDATE_EN; the expectations follow the selected behaviour.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 256 * CLK_DIV;
`ifdef PWM_SHADOW_UPDATE_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    int exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input int obs);
        int want;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) n_pass++;
            else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    // Samples until period_start is seen; n = samples taken (-1 on timeout).
    task automatic wait_ps(input int max_cyc, output int n, output int highs,
                           output int bits);
        logic [15:0] acc;
        n = 0; highs = 0; acc = '0;
        do begin
            @(negedge clk);
            n++;
            if (out[0]) highs++;
            acc |= out;
        end while (!period_start && n < max_cyc);
        if (!period_start) n = -1;
        bits = int'(acc);
    endtask

    // Observes one full period starting right after a period_start sample.
    // Enables are expected to be out=0x8003, pwm=0x8001.
    task automatic run_period(input int change_at, input logic [7:0] new_duty,
                              output int highs, output int first_low,
                              output int after_change, output int bad,
                              output int ps_end);
        highs = 0; first_low = -1; after_change = -1; bad = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (out[0]) highs++;
            else if (first_low < 0) first_low = i;
            if (i == change_at + 1) after_change = int'(out[0]);
            if (out[15] !== out[0] || out[1] !== 1'b1 || (out & 16'h7FFC) != 16'h0)
                bad++;
            if (i < PERIOD - 1 && period_start) bad++;
            if (i == change_at) pwm_duty_cycle = new_duty;
        end
        ps_end = int'(period_start);
    endtask

    int n, h, bits, fl, ac, bad, pse;
    logic [7:0] duties [4] = '{8'h00, 8'h01, 8'hFE, 8'hFF};

    initial begin
        rst_n = 1'b0;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h00;
        repeat (3) @(negedge clk);
        exp_q.push_back(0); check("reset_out", int'(out));
        exp_q.push_back(0); check("reset_period_start", int'(period_start));

        // Idle: nothing enabled, timebase still runs.
        rst_n = 1'b1;
        wait_ps(PERIOD + 16, n, h, bits);
        exp_q.push_back(PERIOD); check("first_period_start", n);
        exp_q.push_back(0);      check("idle_out", bits);
        @(negedge clk);
        exp_q.push_back(0); check("period_start_one_cycle", int'(period_start));
        wait_ps(PERIOD + 16, n, h, bits);
        exp_q.push_back(PERIOD - 1); check("period_start_spacing", n);

        // Constant-on channels, independent of duty; one-clock latency.
        set_en(16'hFFFF, 16'h0000);
        pwm_duty_cycle = 8'h00;
        @(negedge clk);
        exp_q.push_back(16'hFFFF); check("const_on_latency", int'(out));
        pwm_duty_cycle = 8'hFF;
        @(negedge clk);
        exp_q.push_back(16'hFFFF); check("const_on_duty_ff", int'(out));
        pwm_duty_cycle = 8'h5A;
        @(negedge clk);
        exp_q.push_back(16'hFFFF); check("const_on_duty_5a", int'(out));
        set_en(16'h0000, 16'h0000);
        @(negedge clk);
        exp_q.push_back(0); check("disable_latency", int'(out));
        pwm_duty_cycle = 8'h00;
        set_en(16'hFFFF, 16'hFFFF);
        @(negedge clk);
        exp_q.push_back(0); check("pwm_all_duty0", int'(out));

        // PWM from reset at 50 % duty.
        rst_n = 1'b0;
        set_en(16'h8003, 16'h8001);
        pwm_duty_cycle = 8'h80;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps(PERIOD + 16, n, h, bits);
        exp_q.push_back(PERIOD);                   check("pwm_first_ps", n);
        exp_q.push_back(SHADOW ? 0 : 512);         check("pwm_first_period_highs", h);
        exp_q.push_back(SHADOW ? 16'h0002 : 16'h8003); check("pwm_first_period_bits", bits);
        run_period(-1, 8'h00, h, fl, ac, bad, pse);
        exp_q.push_back(512); check("duty80_highs", h);
        exp_q.push_back(512); check("duty80_first_low", fl);
        exp_q.push_back(0);   check("duty80_channels", bad);
        exp_q.push_back(1);   check("duty80_ps_end", pse);

        // Boundary duties, measured on the second period after the write.
        foreach (duties[k]) begin
            pwm_duty_cycle = duties[k];
            run_period(-1, 8'h00, h, fl, ac, bad, pse);
            run_period(-1, 8'h00, h, fl, ac, bad, pse);
            exp_q.push_back(duties[k] == 8'hFF ? PERIOD : int'(duties[k]) * CLK_DIV);
            check($sformatf("duty%02h_highs", duties[k]), h);
            exp_q.push_back(duties[k] == 8'hFF ? -1 : int'(duties[k]) * CLK_DIV);
            check($sformatf("duty%02h_first_low", duties[k]), fl);
            exp_q.push_back(0); check($sformatf("duty%02h_channels", duties[k]), bad);
            exp_q.push_back(1); check($sformatf("duty%02h_ps_end", duties[k]), pse);
        end

        // Mid-period duty change 0x40 -> 0xC0.
        pwm_duty_cycle = 8'h40;
        run_period(-1, 8'h00, h, fl, ac, bad, pse);
        run_period(-1, 8'h00, h, fl, ac, bad, pse);
        exp_q.push_back(256); check("duty40_highs", h);
        run_period(299, 8'hC0, h, fl, ac, bad, pse);
        exp_q.push_back(SHADOW ? 256 : 724); check("midchange_period_highs", h);
        exp_q.push_back(SHADOW ? 0 : 1);     check("midchange_next_clock", ac);
        run_period(-1, 8'h00, h, fl, ac, bad, pse);
        exp_q.push_back(768); check("midchange_next_period_highs", h);
        exp_q.push_back(1);   check("midchange_ps_end", pse);

        // Asynchronous reset while out is high.
        repeat (50) @(negedge clk);
        exp_q.push_back(16'h8003); check("pre_reset_out", int'(out));
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(0); check("async_reset_out", int'(out));
        exp_q.push_back(0); check("async_reset_period_start", int'(period_start));
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps(PERIOD + 16, n, h, bits);
        exp_q.push_back(PERIOD);           check("post_reset_first_ps", n);
        exp_q.push_back(SHADOW ? 0 : 768); check("post_reset_period_highs", h);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

- Consumes the five configuration registers written over SPI: output enables, PWM enables and duty cycle.
- Drives the 16 chip outputs: uo_out[7:0] and uio_out[7:0].
- Generates one shared 8-bit PWM waveform from a prescaled timebase, then gates it per channel.
- Sits directly downstream of the SPI register block and uses the same clk domain.

## Interface
Parameters:
- CLK_DIV, default 13: system clocks per PWM counter tick; legal range 1..65535; PWM period = 256 × CLK_DIV clocks.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en_reg_out_7_0  input  8  output enable for out[7:0].
- en_reg_out_15_8  input  8  output enable for out[15:8].
- en_reg_pwm_7_0  input  8  PWM mode select for out[7:0].
- en_reg_pwm_15_8  input  8  PWM mode select for out[15:8].
- pwm_duty_cycle  input  8  requested duty; 0x00 means 0 %, 0xFF means 100 %.
- out  output  16  channel outputs; [7:0] go to uo_out, [15:8] go to uio_out; registered.
- period_start  output  1  one-clock pulse at the start of every PWM period; registered.

## Operation
- Prescaler:
  - div_cnt runs 0..CLK_DIV-1 and wraps to 0.
  - tick = (div_cnt == CLK_DIV-1).
  - With CLK_DIV = 1, tick is asserted every cycle.
- Period counter:
  - pwm_cnt is 8 bits and increments on tick.
  - It wraps naturally from 255 to 0.
  - wrap = tick && pwm_cnt == 255.
- Duty used for comparison: duty_act (see Configuration).
- PWM level:
  - pwm_level = 1 when duty_act == 0xFF.
  - Otherwise pwm_level = (pwm_cnt < duty_act), as an unsigned 8-bit compare.
  - duty 0x00 gives a constant 0. duty N gives N high ticks per 256-tick period.
- Per-channel output, for i = 0..15:
  - en_out[i] = 0 → out[i] = 0.
  - en_out[i] = 1 and en_pwm[i] = 0 → out[i] = 1.
  - en_out[i] = 1 and en_pwm[i] = 1 → out[i] = pwm_level.
  - en_out and en_pwm are the concatenated {15_8, 7_0} registers.
- Enable inputs are not buffered. A change takes effect on the next clock edge.
- period_start is registered as 1 on the edge where pwm_cnt wraps to 0, and is 0 otherwise.

## Timing
- Reset values: div_cnt = 0, pwm_cnt = 0, duty_act = 0x00, out = 16'h0000, period_start = 0.
- Reset is asynchronous on assertion. Asserting rst_n mid-period returns all state to the reset values immediately.
- After rst_n deasserts, div_cnt increments on the first clk edge.
- out is registered from the current pwm_cnt, duty_act and enables. Latency from an enable change to out is 1 clock.
- Sequence at a period boundary:
  - On the wrap edge, pwm_cnt becomes 0 and period_start becomes 1.
  - On the following edge, out reflects pwm_cnt = 0.
- Constant duty N (0 < N < 255) gives out high for exactly N × CLK_DIV consecutive clocks per 256 × CLK_DIV clocks.
- When a wrap and a duty change happen on the same edge, the edge captures the new duty (see Configuration).
- Inputs are already synchronous to clk. No synchronizers are used.

## Configuration
- Macro: PWM_SHADOW_UPDATE_EN.
- Defined:
  - duty_act is a shadow register, loaded from pwm_duty_cycle only on the wrap edge.
  - Duty changes are glitch-free and apply from the next period.
  - After reset, duty_act = 0x00 until the first wrap, so PWM channels are low for the first period.
- Undefined:
  - duty_act = pwm_duty_cycle combinationally.
  - A duty change affects the compare on the next clock, mid-period.
  - No shadow register is built.

## Structure
- Package pwm_pkg holds:
  - PWM_CNT_W = 8 and NUM_CH = 16.
  - PWM_DUTY_FULL = 8'hFF.
  - The prescaler width derived from CLK_DIV via $clog2, with a minimum of 1.
- Sub-module pwm_timebase:
  - Contains the prescaler, pwm_cnt, tick and wrap.
  - Outputs pwm_cnt and wrap.
- Top level holds duty_act, the compare, the per-channel gating and the output registers.

## Test plan
All scenarios use CLK_DIV = 4, so the period is 1024 clocks.
- Reset then all enables 0 → out = 0x0000 forever; period_start pulses every 1024 clocks.
- en_out = 0xFFFF, en_pwm = 0x0000 → out = 0xFFFF one clock after the enables are written, independent of duty.
- en_out = 0x0001, en_pwm = 0x0001, duty 0x80, with the macro defined → out[0] low for the first period. From the second period, out[0] is high 512 clocks, then low 512 clocks, starting the clock after period_start.
- Duty 0x00 → out[0] constantly 0. Duty 0xFF → out[0] constantly 1, with no low cycle at pwm_cnt = 255.
- Duty changed 0x40 → 0xC0 mid-period:
  - Macro defined: the current period keeps 256 high clocks; the next period gives 768.
  - Macro undefined: the compare changes on the next clock.
- rst_n asserted mid-period with out high → out = 0 and period_start = 0 asynchronously. After release, the first period_start comes 1024 clocks later.
